// File: rtl/bus_wait_pkg.sv
// Shared types and constants for the CPU bus wait-state controller:
// region/state enums, region address map and chip-select bit positions.
package bus_wait_pkg;

  typedef enum logic [1:0] {
    REG_RAM   = 2'd0,
    REG_SDRAM = 2'd1,
    REG_IO    = 2'd2,
    REG_ROM   = 2'd3
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_ACK_WAIT = 2'd2
  } state_t;

  localparam logic [15:0] RAM_BASE    = 16'h0000;
  localparam logic [15:0] RAM_LIMIT   = 16'h7FFF;
  localparam logic [15:0] SDRAM_BASE  = 16'h8000;
  localparam logic [15:0] SDRAM_LIMIT = 16'hBFFF;
  localparam logic [15:0] IO_BASE     = 16'hC000;
  localparam logic [15:0] IO_LIMIT    = 16'hEFFF;
  localparam logic [15:0] ROM_BASE    = 16'hF000;
  localparam logic [15:0] ROM_LIMIT   = 16'hFFFF;

  localparam int unsigned CS_RAM   = 0;
  localparam int unsigned CS_SDRAM = 1;
  localparam int unsigned CS_IO    = 2;
  localparam int unsigned CS_ROM   = 3;

endpackage

// File: rtl/addr_decode.sv
// Combinational CPU address decode into a region code and one-hot chip selects.
module addr_decode
  import bus_wait_pkg::*;
(
  input  logic [15:0] cpu_addr,
  output region_t     region,
  output logic [3:0]  cs
);

  always_comb begin
    region = REG_ROM;
    cs     = '0;
    if (cpu_addr <= RAM_LIMIT) begin
      region       = REG_RAM;
      cs[CS_RAM]   = 1'b1;
    end else if (cpu_addr >= SDRAM_BASE && cpu_addr <= SDRAM_LIMIT) begin
      region       = REG_SDRAM;
      cs[CS_SDRAM] = 1'b1;
    end else if (cpu_addr >= IO_BASE && cpu_addr <= IO_LIMIT) begin
      region       = REG_IO;
      cs[CS_IO]    = 1'b1;
    end else begin
      region       = REG_ROM;
      cs[CS_ROM]   = 1'b1;
    end
  end

endmodule

// File: rtl/bus_wait_ctrl.sv
// CPU bus wait-state controller: stretches IO/ROM cycles by fixed counts and
// SDRAM cycles until dev_ack. Optional ack timeout: define WAIT_TIMEOUT_EN.
module bus_wait_ctrl
  import bus_wait_pkg::*;
#(
  parameter int unsigned WAIT_IO     = 2,
  parameter int unsigned WAIT_ROM    = 1,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk_2,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rwb,
  input  logic        dev_ack,
  output logic        cpu_rdy,
  output logic [3:0]  cs,
  output logic        dev_req,
  output logic        dev_rwb,
  output logic        bus_err
);

  if (WAIT_IO > 15 || WAIT_ROM > 15 || ACK_TIMEOUT < 2 || ACK_TIMEOUT > 255) begin : g_param_check
    $error("bus_wait_ctrl: parameter out of range");
  end

  region_t    region;
  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] n_wait;

  addr_decode u_addr_decode (
    .cpu_addr (cpu_addr),
    .region   (region),
    .cs       (cs)
  );

  assign dev_rwb = cpu_rwb;
  assign n_wait  = (region == REG_IO) ? 4'(WAIT_IO) : 4'(WAIT_ROM);

`ifdef WAIT_TIMEOUT_EN
  logic [7:0] timer, timer_nxt;
`else
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cpu_rdy   = 1'b1;
    dev_req   = 1'b0;
`ifdef WAIT_TIMEOUT_EN
    timer_nxt = timer;
    bus_err   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        case (region)
          REG_SDRAM: begin
            cpu_rdy   = 1'b0;
            dev_req   = 1'b1;
            state_nxt = ST_ACK_WAIT;
`ifdef WAIT_TIMEOUT_EN
            timer_nxt = '0;
`endif
          end
          REG_IO, REG_ROM: begin
            if (n_wait != 4'd0) begin
              cpu_rdy   = 1'b0;
              cnt_nxt   = n_wait - 4'd1;
              state_nxt = ST_WAIT;
            end
          end
          default: ;
        endcase
      end
      ST_WAIT: begin
        if (cnt != 4'd0) begin
          cpu_rdy = 1'b0;
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ACK_WAIT: begin
        cpu_rdy = dev_ack;
        if (dev_ack) begin
          state_nxt = ST_IDLE;
`ifdef WAIT_TIMEOUT_EN
        end else if (timer == 8'(ACK_TIMEOUT - 1)) begin
          cpu_rdy   = 1'b1;
          bus_err   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          timer_nxt = timer + 8'd1;
`endif
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Reset forces the idle-cycle outputs regardless of the in-flight access.
    if (rst) begin
      cpu_rdy = 1'b1;
      dev_req = 1'b0;
`ifdef WAIT_TIMEOUT_EN
      bus_err = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_2) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
`ifdef WAIT_TIMEOUT_EN
      timer <= '0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
`ifdef WAIT_TIMEOUT_EN
      timer <= timer_nxt;
`endif
    end
  end

endmodule

// File: doc/bus_wait_ctrl.md
BUS_WAIT_CTRL -- requirements
Module: bus_wait_ctrl

Interface
REQ-001 Parameter WAIT_IO, 2: number of cpu_rdy-low cycles for an IO-region access (0..15).
REQ-002 Parameter WAIT_ROM, 1: number of cpu_rdy-low cycles for a ROM-region access (0..15).
REQ-003 Parameter ACK_TIMEOUT, 16: maximum ACK_WAIT cycles before forced release (2..255).
REQ-004 Port clk_2  input  1: CPU bus clock; all state advances on the rising edge; single clock domain.
REQ-005 Port rst  input  1: synchronous, active-high reset.
REQ-006 Port cpu_addr  input  16: current CPU address.
REQ-007 Port cpu_rwb  input  1: CPU read (1) / write (0), forwarded to dev_rwb.
REQ-008 Port dev_ack  input  1: external (SDRAM) device completion strobe.
REQ-009 Port cpu_rdy  output  1: CPU RDY; low stretches the current bus cycle.
REQ-010 Port cs  output  4: one-hot chip selects {ROM, IO, SDRAM, RAM} as bits [3:0].
REQ-011 Port dev_req  output  1: one-cycle request pulse to the SDRAM device.
REQ-012 Port dev_rwb  output  1: direction qualifier for dev_req, equal to cpu_rwb.
REQ-013 Port bus_err  output  1: one-cycle pulse on ack timeout.

Function
REQ-014 The decode SHALL be combinational: 0000-7FFF RAM (cs[0]), 8000-BFFF SDRAM (cs[1]), C000-EFFF IO (cs[2]), F000-FFFF ROM (cs[3]); exactly one cs bit is high at all times.
REQ-015 The state machine SHALL have three states: IDLE, WAIT, ACK_WAIT.
REQ-016 In IDLE, a RAM region access, or an IO/ROM access whose wait count N = 0, SHALL drive cpu_rdy=1 and remain in IDLE.
REQ-017 In IDLE, an IO/ROM access with N > 0 SHALL drive cpu_rdy=0, load the 4-bit counter cnt = N-1, and enter WAIT.
REQ-018 In WAIT with cnt != 0, the block SHALL drive cpu_rdy=0 and decrement cnt.
REQ-019 In WAIT with cnt = 0, the block SHALL drive cpu_rdy=1 and return to IDLE, giving exactly N low cycles per access.
REQ-020 In IDLE, an SDRAM access SHALL drive cpu_rdy=0, pulse dev_req=1 for that cycle, clear the 8-bit timer, and enter ACK_WAIT.
REQ-021 In ACK_WAIT, cpu_rdy SHALL equal dev_ack combinationally; dev_ack=1 returns the block to IDLE; otherwise the timer increments.
REQ-022 dev_ack SHALL be ignored outside ACK_WAIT, so an SDRAM access has a minimum of one wait cycle.
REQ-023 The IDLE cycle after any release SHALL decode the new cpu_addr; back-to-back slow accesses re-enter WAIT or ACK_WAIT with no gap cycle.
REQ-024 The address is assumed stable while cpu_rdy=0; decode changes during WAIT or ACK_WAIT SHALL NOT alter the loaded count or the state.
REQ-025 dev_req SHALL never be asserted outside an IDLE cycle with an SDRAM decode.

Reset
REQ-026 While rst=1: state=IDLE, cnt=0, timer=0, cpu_rdy=1, dev_req=0, bus_err=0; cs follows the decode.
REQ-027 Reset asserted during WAIT or ACK_WAIT SHALL abort the access; the first cycle after rst deasserts is IDLE.

Configuration
REQ-028 With macro WAIT_TIMEOUT_EN defined, when the timer reaches ACK_TIMEOUT-1 in ACK_WAIT without dev_ack, the block SHALL drive cpu_rdy=1, pulse bus_err for one cycle, and return to IDLE.
REQ-029 With WAIT_TIMEOUT_EN undefined, ACK_WAIT SHALL wait indefinitely, bus_err SHALL be tied 0, and no timer logic is synthesized.

Structure
REQ-030 Shared package bus_wait_pkg SHALL hold: the region enum (RAM, SDRAM, IO, ROM), the state enum, the region base/limit address constants, and the cs bit indices.
REQ-031 The address decode SHALL be a sub-module, addr_decode (cpu_addr in; region and cs out), reused by the top level.

Verification
REQ-032 Read at 0x1234 after reset -> cs=0001, cpu_rdy=1 every cycle, state stays IDLE.
REQ-033 WAIT_IO=2, read at 0xC010 -> cs=0100, cpu_rdy low for exactly 2 cycles, high on the 3rd, then IDLE.
REQ-034 Write at 0x9000, dev_ack asserted 3 cycles after dev_req -> dev_req single pulse, dev_rwb=0, cpu_rdy low 3 cycles, high in the ack cycle.
REQ-035 WAIT_TIMEOUT_EN defined, ACK_TIMEOUT=16, access at 0x8000 with no ack -> cpu_rdy low 16 cycles, then high with bus_err one-cycle pulse; without the macro, cpu_rdy stays low for 100+ cycles and bus_err=0.
REQ-036 ROM read at 0xFFFC (WAIT_ROM=1) immediately followed by IO read at 0xD000 -> 1 low cycle, release, then 2 low cycles with no gap IDLE.
REQ-037 rst pulsed during the 2nd cycle of an IO wait -> cpu_rdy=1 during reset, IDLE next cycle, no dev_req or bus_err.
